// File: rtl/cp0_regfile.sv
// MIPS coprocessor-0 register block: BadVAddr, Count, Compare, Status, Cause, EPC.
// Handles exception entry / ERET commit, MTC0/MFC0 access and the interrupt request.
// Optional Count/Compare timer is built when the macro CP0_TIMER_EN is defined.
module cp0_regfile #(
    parameter int unsigned NUM_HW_INT = 6,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            addrR,
    input  logic [2:0]            selR,
    output logic [31:0]           dout,
    input  logic [4:0]            addrW,
    input  logic [2:0]            selW,
    input  logic [31:0]           din,
    input  logic                  cp0Write,
    input  logic                  excValid,
    input  logic [4:0]            excCode,
    input  logic [31:0]           excPC,
    input  logic                  excBD,
    input  logic                  badVAddrValid,
    input  logic [31:0]           excBadVAddr,
    input  logic                  eret,
    input  logic [NUM_HW_INT-1:0] hwInt,
    output logic [31:0]           epc,
    output logic                  intReq,
    output logic                  exl
);

    localparam logic [4:0] AddrBadVAddr = 5'd8;
    localparam logic [4:0] AddrCount    = 5'd9;
    localparam logic [4:0] AddrCompare  = 5'd11;
    localparam logic [4:0] AddrStatus   = 5'd12;
    localparam logic [4:0] AddrCause    = 5'd13;
    localparam logic [4:0] AddrEpc      = 5'd14;

    logic [31:0] badvaddr_q;
    logic [31:0] epc_q;
    logic [7:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  ip_hw_q;
    logic [4:0]  exccode_q;

    logic [5:0]  hw_ext;
    logic [7:0]  ip;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;
    logic        ti;

    // MTC0 only commits when no exception or ERET claims the same edge
    logic wr_en;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;
    logic wr_count;
    logic wr_compare;

    assign wr_en      = cp0Write & ~excValid & ~eret & (selW == 3'd0);
    assign wr_status  = wr_en & (addrW == AddrStatus);
    assign wr_cause   = wr_en & (addrW == AddrCause);
    assign wr_epc     = wr_en & (addrW == AddrEpc);
    assign wr_count   = wr_en & (addrW == AddrCount);
    assign wr_compare = wr_en & (addrW == AddrCompare);

    // Widen hwInt to the six architectural lines; unused lines stay 0
    always_comb begin
        hw_ext = '0;
        hw_ext[NUM_HW_INT-1:0] = hwInt;
    end

`ifdef CP0_TIMER_EN
    localparam int unsigned DivW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(COUNT_DIV - 1);

    logic [31:0]     count_q;
    logic [31:0]     compare_q;
    logic [DivW-1:0] div_q;
    logic            ti_q;
    logic            tick;
    logic [31:0]     count_inc;

    assign tick      = (div_q == DivMax);
    assign count_inc = count_q + 32'd1;

    // Count/Compare timer; a Count write overrides the increment, a Compare write clears TI
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            compare_q <= '0;
            div_q     <= '0;
            ti_q      <= 1'b0;
        end else begin
            if (wr_count) begin
                count_q <= din;
                div_q   <= '0;
            end else if (tick) begin
                count_q <= count_inc;
                div_q   <= '0;
            end else begin
                div_q   <= div_q + 1'b1;
            end

            if (wr_compare) begin
                compare_q <= din;
                ti_q      <= 1'b0;
            end else if (!wr_count && tick && (count_inc == compare_q)) begin
                ti_q      <= 1'b1;
            end
        end
    end

    assign count_rd   = count_q;
    assign compare_rd = compare_q;
    assign ti         = ti_q;
`else
    logic unused_timer;

    assign unused_timer = wr_count | wr_compare | (COUNT_DIV == 0);
    assign count_rd     = '0;
    assign compare_rd   = '0;
    assign ti           = 1'b0;
`endif

    // Exception entry, ERET and MTC0 updates to Status/Cause/EPC/BadVAddr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            exccode_q  <= '0;
        end else begin
            ip_hw_q <= hw_ext;
            if (excValid) begin
                exccode_q <= excCode;
                // Nested exception keeps the original return point
                if (!exl_q) begin
                    epc_q <= excPC;
                    bd_q  <= excBD;
                end
                exl_q <= 1'b1;
                if (badVAddrValid) begin
                    badvaddr_q <= excBadVAddr;
                end
            end else if (eret) begin
                exl_q <= 1'b0;
            end else begin
                if (wr_status) begin
                    im_q  <= din[15:8];
                    exl_q <= din[1];
                    ie_q  <= din[0];
                end
                if (wr_cause) begin
                    ip_sw_q <= din[9:8];
                end
                if (wr_epc) begin
                    epc_q <= din;
                end
            end
        end
    end

    assign ip        = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
    assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_rd  = {bd_q, ti, 14'b0, ip, 1'b0, exccode_q, 2'b0};

    // MFC0 read mux; only sel 0 of the mapped registers returns data
    always_comb begin
        dout = '0;
        if (selR == 3'd0) begin
            case (addrR)
                AddrBadVAddr: dout = badvaddr_q;
                AddrCount:    dout = count_rd;
                AddrCompare:  dout = compare_rd;
                AddrStatus:   dout = status_rd;
                AddrCause:    dout = cause_rd;
                AddrEpc:      dout = epc_q;
                default:      dout = '0;
            endcase
        end
    end

    assign epc    = epc_q;
    assign exl    = exl_q;
    assign intReq = ie_q & ~exl_q & (|(ip & im_q));

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile (timer checks only when CP0_TIMER_EN is defined).
module tb_cp0_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  addrR;
    logic [2:0]  selR;
    logic [31:0] dout;
    logic [4:0]  addrW;
    logic [2:0]  selW;
    logic [31:0] din;
    logic        cp0Write;
    logic        excValid;
    logic [4:0]  excCode;
    logic [31:0] excPC;
    logic        excBD;
    logic        badVAddrValid;
    logic [31:0] excBadVAddr;
    logic        eret;
    logic [5:0]  hwInt;
    logic [31:0] epc;
    logic        intReq;
    logic        exl;

    int errors = 0;
    int checks = 0;

    cp0_regfile #(
        .NUM_HW_INT(6),
        .COUNT_DIV (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addrR        (addrR),
        .selR         (selR),
        .dout         (dout),
        .addrW        (addrW),
        .selW         (selW),
        .din          (din),
        .cp0Write     (cp0Write),
        .excValid     (excValid),
        .excCode      (excCode),
        .excPC        (excPC),
        .excBD        (excBD),
        .badVAddrValid(badVAddrValid),
        .excBadVAddr  (excBadVAddr),
        .eret         (eret),
        .hwInt        (hwInt),
        .epc          (epc),
        .intReq       (intReq),
        .exl          (exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [2:0] s,
                            input logic [31:0] exp);
        addrR = a;
        selR  = s;
        #1;
        check(tag, dout, exp);
    endtask

    // One MTC0 commit; returns at the falling edge after the write edge
    task automatic mtc0(input logic [4:0] a, input logic [31:0] v);
        @(negedge clk);
        addrW    = a;
        selW     = 3'd0;
        din      = v;
        cp0Write = 1'b1;
        @(negedge clk);
        cp0Write = 1'b0;
    endtask

    task automatic exc(input logic [31:0] pc, input logic [4:0] code, input logic bd,
                       input logic bv, input logic [31:0] bva);
        @(negedge clk);
        excValid      = 1'b1;
        excPC         = pc;
        excCode       = code;
        excBD         = bd;
        badVAddrValid = bv;
        excBadVAddr   = bva;
        @(negedge clk);
        excValid      = 1'b0;
        badVAddrValid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        addrR = '0; selR = '0; addrW = '0; selW = '0; din = '0; cp0Write = 1'b0;
        excValid = 1'b0; excCode = '0; excPC = '0; excBD = 1'b0;
        badVAddrValid = 1'b0; excBadVAddr = '0; eret = 1'b0; hwInt = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset state
        rd_check("rst_status", 5'd12, 3'd0, 32'h0040_0000);
        rd_check("rst_badvaddr", 5'd8, 3'd0, 32'h0);
        rd_check("rst_count", 5'd9, 3'd0, 32'h0);
        rd_check("rst_compare", 5'd11, 3'd0, 32'h0);
        rd_check("rst_cause", 5'd13, 3'd0, 32'h0);
        rd_check("rst_epc", 5'd14, 3'd0, 32'h0);
        rd_check("rst_sel1", 5'd8, 3'd1, 32'h0);
        check("rst_epc_port", epc, 32'h0);
        check("rst_intreq", {31'b0, intReq}, 32'h0);
        check("rst_exl", {31'b0, exl}, 32'h0);

        // Writable-bit masks
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd_check("status_mask", 5'd12, 3'd0, 32'h0040_FF03);
        check("status_exl", {31'b0, exl}, 32'h1);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd_check("cause_mask", 5'd13, 3'd0, 32'h0000_0300);
        mtc0(5'd12, 32'h0);
        mtc0(5'd13, 32'h0);
        rd_check("status_sel1_ignored", 5'd12, 3'd1, 32'h0);

        // Exception entry, nested exception, ERET
        exc(32'h8000_0100, 5'd4, 1'b1, 1'b1, 32'h1234_5679);
        rd_check("exc_epc", 5'd14, 3'd0, 32'h8000_0100);
        rd_check("exc_cause", 5'd13, 3'd0, 32'h8000_0010);
        rd_check("exc_badvaddr", 5'd8, 3'd0, 32'h1234_5679);
        check("exc_exl", {31'b0, exl}, 32'h1);
        exc(32'h8000_0200, 5'd5, 1'b0, 1'b0, 32'hAAAA_AAAA);
        check("exc2_epc_kept", epc, 32'h8000_0100);
        rd_check("exc2_cause", 5'd13, 3'd0, 32'h8000_0014);
        rd_check("exc2_badvaddr_kept", 5'd8, 3'd0, 32'h1234_5679);
        @(negedge clk);
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
        check("eret_exl", {31'b0, exl}, 32'h0);
        check("eret_epc", epc, 32'h8000_0100);

`ifdef CP0_TIMER_EN
        // Timer: Compare 5, Count 0, two clocks per increment
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        repeat (9) @(negedge clk);
        rd_check("tmr_count4", 5'd9, 3'd0, 32'd4);
        rd_check("tmr_no_ti", 5'd13, 3'd0, 32'h8000_0014);
        @(negedge clk);
        rd_check("tmr_ti", 5'd13, 3'd0, 32'hC000_8014);
        check("tmr_intreq", {31'b0, intReq}, 32'h1);
        mtc0(5'd11, 32'hFFFF_0000);
        rd_check("tmr_ti_clr", 5'd13, 3'd0, 32'h8000_0014);
        check("tmr_intreq_clr", {31'b0, intReq}, 32'h0);
        mtc0(5'd9, 32'h10);
        rd_check("tmr_write_wins", 5'd9, 3'd0, 32'h10);
        mtc0(5'd9, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        rd_check("tmr_wrap", 5'd9, 3'd0, 32'h0);
`else
        mtc0(5'd9, 32'h55);
        rd_check("notmr_count", 5'd9, 3'd0, 32'h0);
        mtc0(5'd11, 32'h5);
        rd_check("notmr_compare", 5'd11, 3'd0, 32'h0);
`endif

        // Hardware interrupt with one cycle latency, masked by EXL
        mtc0(5'd12, 32'h0000_0401);
        hwInt = 6'b000001;
        #1;
        check("hw_lat0", {31'b0, intReq}, 32'h0);
        @(negedge clk);
        check("hw_intreq", {31'b0, intReq}, 32'h1);
        rd_check("hw_cause", 5'd13, 3'd0, 32'h8000_0414);
        mtc0(5'd12, 32'h0000_0403);
        check("hw_exl_mask", {31'b0, intReq}, 32'h0);
        hwInt = 6'b0;
        mtc0(5'd12, 32'h0);

        // Same-edge priority: exception beats ERET beats MTC0
        @(negedge clk);
        excValid = 1'b1; excPC = 32'h8000_0300; excCode = 5'd8; excBD = 1'b0;
        eret = 1'b1;
        addrW = 5'd14; selW = 3'd0; din = 32'hDEAD_BEEF; cp0Write = 1'b1;
        @(negedge clk);
        excValid = 1'b0;
        check("prio_epc", epc, 32'h8000_0300);
        check("prio_exl", {31'b0, exl}, 32'h1);
        rd_check("prio_cause", 5'd13, 3'd0, 32'h0000_0020);
        din = 32'h0000_1111;
        @(negedge clk);
        eret = 1'b0; cp0Write = 1'b0;
        check("prio_eret_exl", {31'b0, exl}, 32'h0);
        check("prio_eret_epc", epc, 32'h8000_0300);

        // Asynchronous reset between clock edges
        mtc0(5'd12, 32'h0000_FF01);
        #2;
        rst = 1'b0;
        #1;
        check("arst_epc", epc, 32'h0);
        rd_check("arst_status", 5'd12, 3'd0, 32'h0040_0000);
        rd_check("arst_cause", 5'd13, 3'd0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        mtc0(5'd14, 32'h0000_4444);
        check("post_rst_write", epc, 32'h0000_4444);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Parametrised MIPS coprocessor-0 block for the CPU core, replacing the plain CP0 register store. Holds BadVAddr, Count, Compare, Status, Cause and EPC. Handles precise exception entry and ERET from the writeback stage, runs the Count/Compare timer and produces the pending-interrupt request sampled by the pipeline. MTC0/MFC0 use the existing addrR/selR/addrW/selW/din/cp0Write/dout/epc port set.

## Interface
- NUM_HW_INT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+i]
- COUNT_DIV, 2, clock cycles per Count increment (>=1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- addrR  in  5  read register number
- selR  in  3  read select
- dout  out  32  read data, combinational from addrR/selR
- addrW  in  5  write register number
- selW  in  3  write select
- din  in  32  write data
- cp0Write  in  1  MTC0 commit strobe
- excValid  in  1  exception commit strobe, one cycle
- excCode  in  5  Cause.ExcCode for this exception
- excPC  in  32  PC of faulting instruction (or of branch if in delay slot)
- excBD  in  1  faulting instruction is in a delay slot
- badVAddrValid  in  1  load BadVAddr on this exception
- excBadVAddr  in  32  faulting address
- eret  in  1  ERET commit strobe
- hwInt  in  NUM_HW_INT  level-sensitive external interrupts
- epc  out  32  current EPC, for ERET target
- intReq  out  1  interrupt pending and enabled
- exl  out  1  Status.EXL

## Operation
- Register map (sel 0 only; any other addr/sel reads 0, writes ignored): 8 BadVAddr (read-only), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
- Reset values: BadVAddr 0, Count 0, Compare 0, Status 0x0040_0000 (BEV=1), Cause 0, EPC 0, divider 0; hence dout per map, epc 0, intReq 0, exl 0.
- Status writable bits: IM[15:8], EXL[1], IE[0]; BEV[22] reads 1, all else 0.
- Cause writable bits: IP[9:8] (software interrupts) only. BD[31], TI[30], IP[15:10], ExcCode[6:2] are hardware-owned.
- Cause.IP[2+i] = hwInt[i] registered each cycle; unused lines read 0. IP[7] = registered hwInt[5] OR TI.
- intReq = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM[15:8]), combinational from registers.
- Exception (excValid): ExcCode <= excCode. If EXL was 0: EPC <= excPC, BD <= excBD. If EXL was 1: EPC and BD unchanged. EXL <= 1. BadVAddr <= excBadVAddr when badVAddrValid.
- ERET: EXL <= 0; nothing else changes.
- Timer: divider counts 0..COUNT_DIV-1; Count increments (wraps 0xFFFF_FFFF -> 0) when divider wraps. TI sets when the new Count equals Compare; TI cleared only by writing Compare.
- Writing Count loads din and resets divider to 0; no increment that cycle.

## Timing
- dout zero-latency combinational read; writes visible on dout the cycle after the cp0Write edge (no same-cycle bypass).
- Priority on one edge: excValid > eret > cp0Write; the lower-priority action is dropped entirely.
- MTC0 to Count and timer increment same cycle: write wins.
- Compare write and Count==Compare match same cycle: TI ends 0.
- hwInt to intReq: one cycle latency through IP register.
- Reset asserted mid-operation: all state returns to reset values asynchronously; first update on first rising edge after rst returns high.

## Configuration
- CP0_TIMER_EN defined: Count, Compare, divider and TI implemented as above.
- Not defined: addr 9 and 11 read 0 and ignore writes, TI reads 0, IP[7] = registered hwInt[5] only; COUNT_DIV unused.

## Test plan
- Reset release, read addr 12 sel 0 -> 0x0040_0000; addr 8/9/11/13/14 -> 0; addr 8 sel 1 -> 0.
- MTC0 Status din 0xFFFF_FFFF -> read 0x0040_FF03; MTC0 Cause 0xFFFF_FFFF -> read 0x0000_0300.
- excValid, excPC 0x8000_0100, excCode 4, excBD 1, badVAddrValid, excBadVAddr 0x1234_5679 -> EPC 0x8000_0100, Cause 0x8000_0010, BadVAddr 0x1234_5679, exl 1; second exception excPC 0x8000_0200 -> EPC unchanged; eret -> exl 0.
- COUNT_DIV=2, write Compare 5, Count 0 -> TI set after 10 cycles, intReq 1 with Status 0x0000_8001; write Compare -> TI 0, intReq 0.
- hwInt[0]=1, Status 0x0000_0401 -> intReq 1 one cycle after hwInt; set EXL via MTC0 -> intReq 0.
- excValid, eret and cp0Write to EPC same edge -> exception effects only, EPC = excPC, exl 1.
